ibex_imem_arbiter: RTL and testbench

IBEX_IMEM_ARBITER -- requirements
Module: ibex_imem_arbiter

---
 rtl/ibex_pkg.sv | 25 ++
 rtl/ibex_imem_arb_route_fifo.sv | 59 +++++
 rtl/ibex_imem_arbiter.sv | 111 +++++++++++
 tb/tb_ibex_imem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the instruction-memory arbiter: requester ids, FSM states and the
// round-robin pick used when both ports request.
package ibex_pkg;

    typedef enum logic {
        ARB_PF = 1'b0,
        ARB_LD = 1'b1
    } imem_arb_port_e;

    typedef logic [0:0] imem_arb_state_t;

    localparam imem_arb_state_t IMEM_ARB    = 1'b0;
    localparam imem_arb_state_t IMEM_LOCKED = 1'b1;

    // On a tie the port that did not win last time goes first.
    function automatic imem_arb_port_e imem_arb_pick(input logic           pf_req,
                                                     input logic           ld_req,
                                                     input imem_arb_port_e last);
        if (pf_req && ld_req) begin
            return (last == ARB_LD) ? ARB_PF : ARB_LD;
        end
        return ld_req ? ARB_LD : ARB_PF;
    endfunction

endpackage

// File: rtl/ibex_imem_arb_route_fifo.sv
// Route queue: remembers which port owns each granted request so that in-order rvalids
// can be steered back. A push while full is accepted only alongside a pop.
module ibex_imem_arb_route_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  imem_arb_port_e push_id_i,
    input  logic           pop_i,
    output imem_arb_port_e head_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    imem_arb_port_e        mem_q [Depth];
    logic [PtrW-1:0]       wptr_q, rptr_q;
    logic [2:0]            count_q;
    logic                  do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty_o = (count_q == 3'd0);
    assign full_o  = (count_q == 3'(Depth));
    assign head_o  = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= ARB_PF;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_id_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 3'd1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 3'd1;
            end
        end
    end

endmodule

// File: rtl/ibex_imem_arbiter.sv
// Two-port instruction-memory arbiter (prefetch buffer, capability/tag loader) with
// round-robin on ties, request locking while the grant is pending, and in-order routing.
module ibex_imem_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pf_req_i,
    input  logic [31:0] pf_addr_i,
    output logic        pf_gnt_o,
    output logic        pf_rvalid_o,
    input  logic        ld_req_i,
    input  logic [31:0] ld_addr_i,
    output logic        ld_gnt_o,
    output logic        ld_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i,
    output logic        busy_o
);

    imem_arb_state_t state_q, state_d;
    imem_arb_port_e  owner_q, owner_d, last_q, last_d;
    imem_arb_port_e  winner, sel, head_id;
    logic            fifo_full, fifo_empty;
    logic            can_issue, req_int, issue, pop;

    assign winner    = imem_arb_pick(pf_req_i, ld_req_i, last_q);
    assign can_issue = ~fifo_full | mem_rvalid_i;

    // While locked the owner is fixed; its address still passes through (branch redirect).
    always_comb begin
        sel     = winner;
        req_int = can_issue & (pf_req_i | ld_req_i);
        if (state_q == IMEM_LOCKED) begin
            sel     = owner_q;
            req_int = (owner_q == ARB_LD) ? ld_req_i : pf_req_i;
        end
    end

    assign mem_req_o  = rst_ni & req_int;
    assign mem_addr_o = !rst_ni ? '0 : (sel == ARB_LD) ? ld_addr_i : pf_addr_i;
    assign issue      = mem_req_o & mem_gnt_i;
    assign pf_gnt_o   = issue & (sel == ARB_PF);
    assign ld_gnt_o   = issue & (sel == ARB_LD);

    assign pop         = rst_ni & mem_rvalid_i & ~fifo_empty;
    assign pf_rvalid_o = pop & (head_id == ARB_PF);
    assign ld_rvalid_o = pop & (head_id == ARB_LD);
    assign rdata_o     = rst_ni ? mem_rdata_i : '0;
    assign busy_o      = mem_req_o | ~fifo_empty;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = issue ? sel : last_q;
        unique case (state_q)
            IMEM_ARB: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d = IMEM_LOCKED;
                    owner_d = winner;
                end
            end
            IMEM_LOCKED: begin
                if (mem_gnt_i) begin
                    state_d = IMEM_ARB;
                end
            end
            default: state_d = IMEM_ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IMEM_ARB;
            owner_q <= ARB_PF;
            last_q  <= ARB_LD;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    ibex_imem_arb_route_fifo #(
        .Depth(MaxOutstanding)
    ) u_route_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_i   (issue),
        .push_id_i(sel),
        .pop_i    (pop),
        .head_o   (head_id),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    // Stray rvalid (nothing outstanding) is dropped by the logic above; flag it.
    rvalid_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> !fifo_empty)
        else $warning("imem arbiter: rvalid with no outstanding request ignored");

    owner_holds_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == IMEM_LOCKED) |-> ((owner_q == ARB_LD) ? ld_req_i : pf_req_i));

endmodule

// File: tb/tb_ibex_imem_arbiter.sv
// Randomised and directed bench for ibex_imem_arbiter, checked against a queue-based
// model of the arbitration and in-order return rules.
module tb_ibex_imem_arbiter;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        pf_req_i = 1'b0, ld_req_i = 1'b0;
    logic [31:0] pf_addr_i = '0, ld_addr_i = '0;
    logic        pf_gnt_o, ld_gnt_o, pf_rvalid_o, ld_rvalid_o;
    logic [31:0] rdata_o, mem_addr_o;
    logic        mem_req_o, busy_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    ibex_imem_arbiter #(
        .MaxOutstanding(MAX)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .pf_req_i    (pf_req_i),
        .pf_addr_i   (pf_addr_i),
        .pf_gnt_o    (pf_gnt_o),
        .pf_rvalid_o (pf_rvalid_o),
        .ld_req_i    (ld_req_i),
        .ld_addr_i   (ld_addr_i),
        .ld_gnt_o    (ld_gnt_o),
        .ld_rvalid_o (ld_rvalid_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_rvalid_i(mem_rvalid_i),
        .busy_o      (busy_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: ids of granted-but-unreturned requests, pending lock, last winner (0=PF, 1=LD).
    int q[$];
    bit m_lock  = 1'b0;
    int m_owner = 0;
    int m_last  = 1;

    logic exp_pf_gnt, exp_ld_gnt;
    logic obs_mem_req, obs_pf_gnt, obs_ld_gnt, obs_pf_rv, obs_ld_rv, obs_busy;
    logic [31:0] obs_addr, obs_rdata;

    task automatic model_reset();
        q.delete();
        m_lock = 1'b0;
        m_owner = 0;
        m_last = 1;
    endtask

    task automatic step(input logic pr, input logic [31:0] pa, input logic lr,
                        input logic [31:0] la, input logic g, input logic rv,
                        input logic [31:0] rd);
        int   sel;
        logic ereq, can, epop;
        int   head;
        @(negedge clk);
        pf_req_i = pr; pf_addr_i = pa; ld_req_i = lr; ld_addr_i = la;
        mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
        #2;
        can = (q.size() < MAX) || rv;
        if (m_lock) begin
            sel  = m_owner;
            ereq = (sel == 1) ? lr : pr;
        end else begin
            if (pr && lr) sel = (m_last == 1) ? 0 : 1;
            else          sel = lr ? 1 : 0;
            ereq = can && (pr || lr);
        end
        epop = rv && (q.size() > 0);
        head = epop ? q[0] : 0;
        exp_pf_gnt = ereq && g && (sel == 0);
        exp_ld_gnt = ereq && g && (sel == 1);
        obs_mem_req = mem_req_o; obs_addr = mem_addr_o; obs_pf_gnt = pf_gnt_o;
        obs_ld_gnt = ld_gnt_o; obs_pf_rv = pf_rvalid_o; obs_ld_rv = ld_rvalid_o;
        obs_rdata = rdata_o; obs_busy = busy_o;
        check("mem_req", 32'(mem_req_o), 32'(ereq));
        if (ereq) check("mem_addr", mem_addr_o, (sel == 1) ? la : pa);
        check("pf_gnt", 32'(pf_gnt_o), 32'(exp_pf_gnt));
        check("ld_gnt", 32'(ld_gnt_o), 32'(exp_ld_gnt));
        check("pf_rvalid", 32'(pf_rvalid_o), 32'(epop && head == 0));
        check("ld_rvalid", 32'(ld_rvalid_o), 32'(epop && head == 1));
        if (epop) check("rdata", rdata_o, rd);
        check("busy", 32'(busy_o), 32'(ereq || q.size() > 0));
        @(posedge clk);
        if (epop) void'(q.pop_front());
        if (ereq && g) begin
            q.push_back(sel);
            m_last = sel;
            m_lock = 1'b0;
        end else if (ereq && !m_lock) begin
            m_lock  = 1'b1;
            m_owner = sel;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, $urandom);
        end
    endtask

    initial begin
        logic        pr, lr;
        logic [31:0] pa, la;

        // Outputs are held low during reset even with live inputs.
        pf_req_i = 1'b1; ld_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rdata_i = 32'hdead_beef;
        pf_addr_i = 32'h40;
        #12;
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_pf_gnt", 32'(pf_gnt_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        pf_req_i = 1'b0; ld_req_i = 1'b0; mem_gnt_i = 1'b0;
        rst_ni = 1'b1;

        // Simultaneous requests from reset: PF first, then alternation.
        step(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1, 1'b0, '0);
        check("t1_pf_first", 32'(obs_pf_gnt), 32'd1);
        check("t1_addr0", obs_addr, 32'h1000);
        step(1'b1, 32'h1004, 1'b1, 32'h2000, 1'b1, 1'b1, 32'h11);
        check("t1_ld_second", 32'(obs_ld_gnt), 32'd1);
        check("t1_addr1", obs_addr, 32'h2000);
        step(1'b1, 32'h1004, 1'b1, 32'h2004, 1'b1, 1'b1, 32'h12);
        check("t1_addr2", obs_addr, 32'h1004);
        step(1'b1, 32'h1008, 1'b1, 32'h2004, 1'b1, 1'b1, 32'h13);
        check("t1_addr3", obs_addr, 32'h2004);
        drain();

        // PF locks, its address moves during the stall, LD is kept out.
        step(1'b1, 32'h100, 1'b0, '0, 1'b0, 1'b0, '0);
        check("t2_ld_gnt0", 32'(obs_ld_gnt), 32'd0);
        step(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 1'b0, '0);
        check("t2_ld_gnt1", 32'(obs_ld_gnt), 32'd0);
        step(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, '0);
        check("t2_ld_gnt2", 32'(obs_ld_gnt), 32'd0);
        check("t2_addr_follow", obs_addr, 32'h200);
        step(1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 1'b0, '0);
        check("t2_pf_gnt", 32'(obs_pf_gnt), 32'd1);
        check("t2_ld_gnt3", 32'(obs_ld_gnt), 32'd0);
        check("t2_addr_gnt", obs_addr, 32'h200);
        step(1'b0, '0, 1'b1, 32'h300, 1'b1, 1'b0, '0);
        drain();

        // Queue full: no request until an rvalid frees a slot in the same cycle.
        step(1'b1, 32'h400, 1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b1, 32'h404, 1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b1, 32'h408, 1'b1, 32'h500, 1'b1, 1'b0, '0);
        check("t3_blocked0", 32'(obs_mem_req), 32'd0);
        step(1'b1, 32'h408, 1'b1, 32'h500, 1'b1, 1'b0, '0);
        check("t3_blocked1", 32'(obs_mem_req), 32'd0);
        step(1'b1, 32'h408, 1'b1, 32'h500, 1'b1, 1'b1, 32'h77);
        check("t3_req_on_rvalid", 32'(obs_mem_req), 32'd1);
        check("t3_ld_gnt", 32'(obs_ld_gnt), 32'd1);
        step(1'b1, 32'h408, 1'b0, '0, 1'b1, 1'b1, 32'h78);
        drain();

        // In-order return routing PF, LD, PF.
        step(1'b1, 32'h600, 1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b1, 32'h700, 1'b1, 1'b0, '0);
        step(1'b1, 32'h604, 1'b0, '0, 1'b1, 1'b1, 32'hA);
        check("t4_pf_rv_a", 32'(obs_pf_rv), 32'd1);
        check("t4_data_a", obs_rdata, 32'hA);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'hB);
        check("t4_ld_rv_b", 32'(obs_ld_rv), 32'd1);
        check("t4_pf_rv_b", 32'(obs_pf_rv), 32'd0);
        check("t4_data_b", obs_rdata, 32'hB);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'hC);
        check("t4_pf_rv_c", 32'(obs_pf_rv), 32'd1);
        check("t4_data_c", obs_rdata, 32'hC);

        // Reset with one outstanding, then a stray rvalid.
        step(1'b1, 32'h800, 1'b0, '0, 1'b1, 1'b0, '0);
        #3;
        rst_ni = 1'b0;
        pf_req_i = 1'b0;
        #1;
        check("t5_busy_in_rst", 32'(busy_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'h55);
        check("t5_no_pf_rv", 32'(obs_pf_rv), 32'd0);
        check("t5_no_ld_rv", 32'(obs_ld_rv), 32'd0);
        check("t5_busy", 32'(obs_busy), 32'd0);
        // Count restarted at 0: two grants fit before blocking.
        step(1'b1, 32'h900, 1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b1, 32'h904, 1'b0, '0, 1'b1, 1'b0, '0);
        check("t5_second_gnt", 32'(obs_pf_gnt), 32'd1);
        drain();

        // Random traffic obeying the hold-until-grant rule.
        pr = 1'b0; lr = 1'b0; pa = '0; la = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pr || exp_pf_gnt) pr = ($urandom_range(0, 2) != 0);
            if (!lr || exp_ld_gnt) lr = ($urandom_range(0, 2) == 0);
            pa = $urandom & 32'hffff_fffc;
            la = $urandom & 32'hffff_fffc;
            step(pr, pa, lr, la, ($urandom_range(0, 3) != 0),
                 (q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom);
            if (!pr) exp_pf_gnt = 1'b0;
            if (!lr) exp_ld_gnt = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
